// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster constants and a small window-decode helper
// shared by the VGA timing generator and its axis counters.
package vga_timing_pkg;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam int DEF_POS_W     = 10;

  localparam int DEF_H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  function automatic logic in_window(input int val, input int lo, input int hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: mod-TOTAL counter holding the next position to present,
// plus the registered presented position and sync level.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL    = DEF_H_TOTAL,
  parameter int DISP     = DEF_H_DISPLAY,
  parameter int SYNC_LO  = DEF_H_SYNC_START,
  parameter int SYNC_HI  = DEF_H_SYNC_END,
  parameter int POS_W    = DEF_POS_W,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  output logic [POS_W-1:0] cnt_o,
  output logic [POS_W-1:0] pos_o,
  output logic             in_disp_o,
  output logic             sync_o
);

  localparam logic [POS_W-1:0] LAST = POS_W'(TOTAL - 1);

  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             sync_q, sync_d;
  int               cnt_int;

  assign cnt_int = int'(cnt_q);

  // cnt_q leads the presented position by one advance, so decode is registered
  always_comb begin
    cnt_d  = cnt_q;
    pos_d  = pos_q;
    sync_d = sync_q;
    if (step_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
    if (load_i) begin
      pos_d  = cnt_q;
      sync_d = in_window(cnt_int, SYNC_LO, SYNC_HI) ? SYNC_POL : ~SYNC_POL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      pos_q  <= '0;
      sync_q <= ~SYNC_POL;
    end else begin
      cnt_q  <= cnt_d;
      pos_q  <= pos_d;
      sync_q <= sync_d;
    end
  end

  assign in_disp_o = (cnt_int < DISP);
  assign cnt_o     = cnt_q;
  assign pos_o     = pos_q;
  assign sync_o    = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: H/V axis counters, display-active flag and
// line/frame strobes, all registered and aligned to the presented pixel.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = 1'b0,
  parameter int POS_W     = DEF_POS_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_Pix_En,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Display_On,
  output logic [POS_W-1:0] o_HPos,
  output logic [POS_W-1:0] o_VPos,
  output logic             o_Line_Start,
  output logic             o_Frame_Start,
  output logic             o_Frame_End
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [POS_W-1:0] H_LAST  = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_VBLNK = POS_W'(V_DISPLAY);

  logic [POS_W-1:0] h_cnt, v_cnt;
  logic             h_in_disp, v_in_disp;
  logic             h_wrap;

  logic disp_q, disp_d;
  logic line_q, line_d;
  logic fstart_q, fstart_d;
  logic fend_q, fend_d;

  assign h_wrap = i_Pix_En && (h_cnt == H_LAST);

  vga_axis_counter #(
    .TOTAL    (H_TOTAL),
    .DISP     (H_DISPLAY),
    .SYNC_LO  (H_DISPLAY + H_FRONT),
    .SYNC_HI  (H_DISPLAY + H_FRONT + H_SYNC),
    .POS_W    (POS_W),
    .SYNC_POL (SYNC_POL)
  ) u_h_axis (
    .clk_i     (i_Clk),
    .rst_ni    (i_Rst_L),
    .load_i    (i_Pix_En),
    .step_i    (i_Pix_En),
    .cnt_o     (h_cnt),
    .pos_o     (o_HPos),
    .in_disp_o (h_in_disp),
    .sync_o    (o_HSync)
  );

  // V presents on every pixel advance so it stays aligned with H; it counts only on H wrap
  vga_axis_counter #(
    .TOTAL    (V_TOTAL),
    .DISP     (V_DISPLAY),
    .SYNC_LO  (V_DISPLAY + V_FRONT),
    .SYNC_HI  (V_DISPLAY + V_FRONT + V_SYNC),
    .POS_W    (POS_W),
    .SYNC_POL (SYNC_POL)
  ) u_v_axis (
    .clk_i     (i_Clk),
    .rst_ni    (i_Rst_L),
    .load_i    (i_Pix_En),
    .step_i    (h_wrap),
    .cnt_o     (v_cnt),
    .pos_o     (o_VPos),
    .in_disp_o (v_in_disp),
    .sync_o    (o_VSync)
  );

  always_comb begin
    disp_d   = i_Pix_En ? (h_in_disp && v_in_disp) : disp_q;
    line_d   = i_Pix_En && (h_cnt == '0);
    fstart_d = line_d && (v_cnt == '0);
    fend_d   = line_d && (v_cnt == V_VBLNK);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      disp_q   <= 1'b0;
      line_q   <= 1'b0;
      fstart_q <= 1'b0;
      fend_q   <= 1'b0;
    end else begin
      disp_q   <= disp_d;
      line_q   <= line_d;
      fstart_q <= fstart_d;
      fend_q   <= fend_d;
    end
  end

  assign o_Display_On  = disp_q;
  assign o_Line_Start  = line_q;
  assign o_Frame_Start = fstart_q;
  assign o_Frame_End   = fend_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus a tiny-raster instance,
// both compared every cycle against an arithmetic pixel-index reference model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;

  always #5 clk = ~clk;

  logic       a_hs, a_vs, a_de, a_ls, a_fs, a_fe;
  logic [9:0] a_hp, a_vp;
  logic       b_hs, b_vs, b_de, b_ls, b_fs, b_fe;
  logic [3:0] b_hp, b_vp;

  vga_timing_gen u_dut_a (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Pix_En      (pix_en),
    .o_HSync       (a_hs),
    .o_VSync       (a_vs),
    .o_Display_On  (a_de),
    .o_HPos        (a_hp),
    .o_VPos        (a_vp),
    .o_Line_Start  (a_ls),
    .o_Frame_Start (a_fs),
    .o_Frame_End   (a_fe)
  );

  vga_timing_gen #(
    .H_DISPLAY (4), .H_FRONT (1), .H_SYNC (2), .H_BACK (1),
    .V_DISPLAY (3), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
    .SYNC_POL  (1'b1), .POS_W (4)
  ) u_dut_b (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Pix_En      (pix_en),
    .o_HSync       (b_hs),
    .o_VSync       (b_vs),
    .o_Display_On  (b_de),
    .o_HPos        (b_hp),
    .o_VPos        (b_vp),
    .o_Line_Start  (b_ls),
    .o_Frame_Start (b_fs),
    .o_Frame_End   (b_fe)
  );

  int checks = 0;
  int failures = 0;

  // Reference state: number of enabled edges since reset, and whether the latest edge was enabled
  longint n_edges = 0;
  bit     started = 1'b0;
  bit     last_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_dut(input string pfx,
                           input int hd, input int hf, input int hs, input int hb,
                           input int vd, input int vf, input int vs, input int vb,
                           input bit pol,
                           input logic hs_o, input logic vs_o, input logic de_o,
                           input logic [31:0] hp_o, input logic [31:0] vp_o,
                           input logic ls_o, input logic fs_o, input logic fe_o);
    int     ht, vt, h, v;
    longint p;
    logic   e_hs, e_vs, e_de, e_ls, e_fs, e_fe;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    h = 0;
    v = 0;
    if (started) begin
      p = n_edges - 1;
      h = int'(p % ht);
      v = int'((p / ht) % vt);
    end
    e_de = started && (h < hd) && (v < vd);
    e_hs = (started && (h >= hd + hf) && (h < hd + hf + hs)) ? pol : ~pol;
    e_vs = (started && (v >= vd + vf) && (v < vd + vf + vs)) ? pol : ~pol;
    e_ls = started && last_en && (h == 0);
    e_fs = e_ls && (v == 0);
    e_fe = e_ls && (v == vd);
    chk({pfx, ".hpos"},  hp_o, h);
    chk({pfx, ".vpos"},  vp_o, v);
    chk({pfx, ".de"},    de_o, e_de);
    chk({pfx, ".hsync"}, hs_o, e_hs);
    chk({pfx, ".vsync"}, vs_o, e_vs);
    chk({pfx, ".line"},  ls_o, e_ls);
    chk({pfx, ".fstart"}, fs_o, e_fs);
    chk({pfx, ".fend"},  fe_o, e_fe);
  endtask

  task automatic check_all();
    check_dut("a", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0,
              a_hs, a_vs, a_de, 32'(a_hp), 32'(a_vp), a_ls, a_fs, a_fe);
    check_dut("b", 4, 1, 2, 1, 3, 1, 1, 1, 1'b1,
              b_hs, b_vs, b_de, 32'(b_hp), 32'(b_vp), b_ls, b_fs, b_fe);
  endtask

  // Drive one clock with the given enable, advance the model, check on the falling edge
  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    if (rst_n) begin
      last_en = en;
      if (en) begin
        n_edges++;
        started = 1'b1;
      end
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic async_reset(input int hold_cycles);
    #2;
    rst_n = 1'b0;
    n_edges = 0;
    started = 1'b0;
    last_en = 1'b0;
    #1;
    check_all();
    for (int i = 0; i < hold_cycles; i++) step(1'($urandom_range(1, 0)));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    pix_en = 1'b0;
    @(negedge clk);
    check_all();
    for (int i = 0; i < 4; i++) step(1'($urandom_range(1, 0)));
    rst_n = 1'b1;
    step(1'b0);
    // First enabled edge presents (0,0) with both start strobes
    step(1'b1);
    // Two full default lines cover the HSync window and many small-raster frames
    for (int i = 0; i < 1700; i++) step(1'b1);
    for (int i = 0; i < 400; i++) step(i[0] == 1'b0);
    for (int i = 0; i < 2000; i++) step(($urandom_range(3, 0)) != 0);
    async_reset(3);
    for (int i = 0; i < 900; i++) step(($urandom_range(4, 0)) != 0);
    async_reset(2);
    for (int i = 0; i < 300; i++) step(1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
